// File: rtl/trig_pulse_shaper.sv
// Trigger pulse shaper: synchronizes the muxed trigger, detects rising edges and emits one
// fixed-length pulse per accepted edge, followed by a programmable dead time. Saturating counters track accepts and vetoes.
module trig_pulse_shaper #(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_BITS    = 8,
  parameter int COUNT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig_in,
  input  logic                  enable,
  input  logic [LEN_BITS-1:0]   pulse_len,
  input  logic [LEN_BITS-1:0]   holdoff_len,
  input  logic                  count_clr,
  output logic                  trig_out,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] trig_count,
  output logic [COUNT_BITS-1:0] veto_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_sync_d;
  logic                  w_sync;
  logic                  w_edge;
  logic                  w_accept;
  logic                  w_veto;
  logic [LEN_BITS-1:0]   r_cnt;
  logic [LEN_BITS-1:0]   w_cnt_nxt;
  logic [LEN_BITS-1:0]   r_ho_q;
  logic [LEN_BITS-1:0]   w_ho_nxt;
  logic                  w_trig_nxt;
  logic                  w_busy_nxt;

  // A zero pulse length still produces a one-cycle pulse.
  function automatic logic [LEN_BITS-1:0] pulse_load(input logic [LEN_BITS-1:0] len);
    if (len == '0) begin
      return '0;
    end
    return len - LEN_BITS'(1);
  endfunction

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] val);
    if (val == '1) begin
      return val;
    end
    return val + COUNT_BITS'(1);
  endfunction

  // Stage 0: synchronizer and edge detect. Reset to ones so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], trig_in};
      r_sync_d <= w_sync;
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_edge   = w_sync & ~r_sync_d;
  assign w_accept = w_edge & enable & (r_state == S_IDLE);
  assign w_veto   = w_edge & enable & (r_state != S_IDLE);

  // Stage 1: FSM state register, dead-time counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ho_q   <= '0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ho_q   <= w_ho_nxt;
      trig_out <= w_trig_nxt;
      busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ho_nxt    = r_ho_q;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = pulse_load(pulse_len);
          w_ho_nxt    = holdoff_len;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          if (r_ho_q == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLDOFF;
            w_cnt_nxt   = r_ho_q - LEN_BITS'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - LEN_BITS'(1);
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - LEN_BITS'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they rise on the accepting edge.
  always_comb begin
    w_trig_nxt = (w_state_nxt == S_PULSE);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Stage 2: slow-control counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || count_clr) begin
      trig_count <= '0;
      veto_count <= '0;
    end else begin
      if (w_accept) begin
        trig_count <= sat_inc(trig_count);
      end
      if (w_veto) begin
        veto_count <= sat_inc(veto_count);
      end
    end
  end

endmodule

// File: tb/tb_trig_pulse_shaper.sv
// Scoreboard bench for trig_pulse_shaper: a timeline model predicts outputs every cycle,
// a monitor compares them with the DUT on the falling edge.
module tb_trig_pulse_shaper;

  localparam int SYNC = 2;
  localparam int LB   = 8;
  localparam int CB   = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig_in;
  logic          enable;
  logic [LB-1:0] pulse_len;
  logic [LB-1:0] holdoff_len;
  logic          count_clr;
  logic          trig_out;
  logic          busy;
  logic [CB-1:0] trig_count;
  logic [CB-1:0] veto_count;

  trig_pulse_shaper #(
    .SYNC_STAGES(SYNC),
    .LEN_BITS   (LB),
    .COUNT_BITS (CB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_in    (trig_in),
    .enable     (enable),
    .pulse_len  (pulse_len),
    .holdoff_len(holdoff_len),
    .count_clr  (count_clr),
    .trig_out   (trig_out),
    .busy       (busy),
    .trig_count (trig_count),
    .veto_count (veto_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit to;
    bit bz;
    int tc;
    int vc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: trig_in samples history, time of last accept and its latched lengths.
  bit hist [0:SYNC];
  int n      = 0;
  bit acc    = 0;
  int a      = 0;
  int p_lat  = 1;
  int h_lat  = 0;
  int m_tc   = 0;
  int m_vc   = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   edg;
    bit   in_dead;
    if (rst) begin
      for (int i = 0; i <= SYNC; i++) hist[i] = 1'b1;
      acc  = 0;
      m_tc = 0;
      m_vc = 0;
    end else begin
      edg     = hist[SYNC-1] && !hist[SYNC];
      in_dead = acc && (n <= a + p_lat + h_lat);
      if (edg && enable) begin
        if (!in_dead) begin
          acc   = 1;
          a     = n;
          p_lat = (pulse_len == 0) ? 1 : int'(pulse_len);
          h_lat = int'(holdoff_len);
          if (m_tc < CMAX) m_tc++;
        end else if (m_vc < CMAX) begin
          m_vc++;
        end
      end
      if (count_clr) begin
        m_tc = 0;
        m_vc = 0;
      end
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = trig_in;
    end
    e.cyc = n;
    e.to  = acc && (n >= a) && (n <= a + p_lat - 1);
    e.bz  = acc && (n >= a) && (n <= a + p_lat + h_lat - 1);
    e.tc  = m_tc;
    e.vc  = m_vc;
    sb.push_back(e);
    n++;
  end

  task automatic chk(input string nm, input int cyc, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("trig_out", e.cyc, int'(trig_out), int'(e.to));
      chk("busy", e.cyc, int'(busy), int'(e.bz));
      chk("trig_count", e.cyc, int'(trig_count), e.tc);
      chk("veto_count", e.cyc, int'(veto_count), e.vc);
    end
  end

  task automatic pulse(input int hi, input int lo);
    trig_in = 1'b1;
    repeat (hi) @(negedge clk);
    trig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    trig_in     = 1'b1;
    enable      = 1'b1;
    pulse_len   = LB'(4);
    holdoff_len = LB'(3);
    count_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // trig_in still high after reset release: no pulse expected
    repeat (8) @(negedge clk);
    trig_in = 1'b0;
    repeat (4) @(negedge clk);

    pulse(5, 12);
    pulse(1, 6);
    pulse(1, 14);
    pulse(1, 7);
    pulse(1, 15);

    pulse_len   = LB'(0);
    holdoff_len = LB'(0);
    count_clr   = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    repeat (10) pulse(1, 1);
    repeat (4) @(negedge clk);

    enable = 1'b0;
    repeat (5) pulse(1, 2);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    trig_in = 1'b1;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    trig_in = 1'b0;
    repeat (3) @(negedge clk);

    repeat (20) pulse(1, 1);
    repeat (4) @(negedge clk);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    repeat (4) @(negedge clk);

    pulse_len   = LB'(10);
    holdoff_len = LB'(2);
    pulse(1, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      trig_in   = ($urandom_range(0, 99) < 40);
      enable    = ($urandom_range(0, 9) != 0);
      count_clr = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) begin
        pulse_len   = LB'($urandom_range(0, 5));
        holdoff_len = LB'($urandom_range(0, 4));
      end
      @(negedge clk);
    end
    rst       = 1'b0;
    count_clr = 1'b0;
    trig_in   = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
